tag_ctrl: RTL and testbench

- Controller for one cache way's tag RAM: a dual-port block RAM with a write port A and a registered read port B, both on the same clock.
- Sequences the post-reset and flush clear sweep.
- Arbitrates the single write port between invalidate and refill requests.
- Issues lookups and compares the stored tag against the request, with same-cycle write forwarding.
- Sits between the cache FSM (I- or D-cache) and the tag RAM instance.

---
 rtl/tag_ctrl_pkg.sv | 26 ++
 rtl/tag_ctrl.sv | 163 ++++++++++++++++
 tb/tb_tag_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_ctrl_pkg.sv
// ============================================================================
// Module : tag_ctrl_pkg
// Brief  : Shared cache tag types, FSM states and default widths.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tag_ctrl_pkg;

   localparam int c_tag_w = 20;
   localparam int c_idx_w = 7;

   typedef struct packed {
      logic               v;
      logic [c_tag_w-1:0] tag;
   } tag_entry_t;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      IDLE  = 2'd1,
      FLUSH = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/tag_ctrl.sv
// ============================================================================
// Module : tag_ctrl
// Brief  : Tag RAM controller for one cache way: clear sweep, write-port
//          arbitration (invalidate over refill), lookup with write forwarding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tag_ctrl
   import tag_ctrl_pkg::*;
#(
   parameter int TAG_W = c_tag_w,
   parameter int IDX_W = c_idx_w
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             lookup_valid,
   input  logic [IDX_W-1:0] lookup_index,
   input  logic [TAG_W-1:0] lookup_tag,
   output logic             lookup_ready,
   output logic             res_valid,
   output logic             res_hit,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_v,
   input  logic             refill_valid,
   input  logic [IDX_W-1:0] refill_index,
   input  logic [TAG_W-1:0] refill_tag,
   output logic             refill_ready,
   input  logic             inv_valid,
   input  logic [IDX_W-1:0] inv_index,
   output logic             inv_ready,
   input  logic             flush_req,
   output logic             busy,
   output logic             ram_ena,
   output logic             ram_wea,
   output logic [IDX_W-1:0] ram_addra,
   output logic [TAG_W:0]   ram_dina,
   output logic             ram_enb,
   output logic [IDX_W-1:0] ram_addrb,
   input  logic [TAG_W:0]   ram_doutb
);

   typedef struct packed {
      logic             v;
      logic [TAG_W-1:0] tag;
   } entry_t;

   localparam logic [IDX_W:0] c_last = {1'b0, {IDX_W{1'b1}}};

   state_t           r_state;
   logic [IDX_W:0]   r_cnt;
   logic             r_busy;

   logic             r_res_valid;
   logic [TAG_W-1:0] r_lk_tag;
   logic             r_fwd;
   entry_t           r_fwd_data;

   logic             w_sweep;
   logic             w_open;
   logic             w_inv_acc;
   logic             w_ref_acc;
   logic             w_wr_acc;
   logic             w_lk_acc;
   logic [IDX_W-1:0] w_wr_idx;
   entry_t           w_wr_data;
   entry_t           w_res;

   // Sweep writes are gated by resetn so the RAM port is idle while reset is held.
   assign w_sweep      = resetn && (r_state != IDLE);
   assign w_open       = (r_state == IDLE) && !flush_req;

   assign lookup_ready = w_open;
   assign inv_ready    = w_open;
   assign refill_ready = w_open && !inv_valid;

   assign w_inv_acc    = inv_valid    && inv_ready;
   assign w_ref_acc    = refill_valid && refill_ready;
   assign w_wr_acc     = w_inv_acc || w_ref_acc;
   assign w_lk_acc     = lookup_valid && lookup_ready;

   always_comb begin
      w_wr_idx      = refill_index;
      w_wr_data.v   = 1'b1;
      w_wr_data.tag = refill_tag;
      if (w_sweep) begin
         w_wr_idx  = r_cnt[IDX_W-1:0];
         w_wr_data = '0;
      end else if (w_inv_acc) begin
         w_wr_idx  = inv_index;
         w_wr_data = '0;
      end
   end

   assign ram_ena   = w_sweep || w_wr_acc;
   assign ram_wea   = w_sweep || w_wr_acc;
   assign ram_addra = w_wr_idx;
   assign ram_dina  = w_wr_data;

   assign ram_enb   = w_lk_acc;
   assign ram_addrb = lookup_index;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= INIT;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (flush_req) begin
                  r_state <= FLUSH;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            INIT, FLUSH: begin
               if (r_cnt == c_last) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt   <= r_cnt + (IDX_W+1)'(1);
               end
            end
            default: begin
               r_state <= INIT;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   assign busy = r_busy;

   // The RAM read returns pre-write data, so a same-cycle write to the looked-up
   // index is captured here and substituted for ram_doutb in the result cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_res_valid <= 1'b0;
         r_lk_tag    <= '0;
         r_fwd       <= 1'b0;
         r_fwd_data  <= '0;
      end else begin
         r_res_valid <= w_lk_acc;
         if (w_lk_acc) begin
            r_lk_tag   <= lookup_tag;
            r_fwd      <= w_wr_acc && (w_wr_idx == lookup_index);
            r_fwd_data <= w_wr_data;
         end
      end
   end

   assign w_res     = r_fwd ? r_fwd_data : entry_t'(ram_doutb);
   assign res_valid = r_res_valid;
   assign res_v     = w_res.v;
   assign res_tag   = w_res.tag;
   assign res_hit   = w_res.v && (w_res.tag == r_lk_tag);

endmodule

`default_nettype wire

// File: tb/tb_tag_ctrl.sv
// ============================================================================
// Module : tb_tag_ctrl
// Brief  : Vector table plus scoreboard bench for tag_ctrl with a tag RAM model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tag_ctrl;

   localparam int TW = 20;
   localparam int IW = 3;
   localparam int N  = 8;

   logic          clk = 1'b0;
   logic          resetn;
   logic          lookup_valid, refill_valid, inv_valid, flush_req;
   logic [IW-1:0] lookup_index, refill_index, inv_index;
   logic [TW-1:0] lookup_tag, refill_tag;
   logic          lookup_ready, refill_ready, inv_ready;
   logic          res_valid, res_hit, res_v, busy;
   logic [TW-1:0] res_tag;
   logic          ram_ena, ram_wea, ram_enb;
   logic [IW-1:0] ram_addra, ram_addrb;
   logic [TW:0]   ram_dina, ram_doutb;

   tag_ctrl #(.TAG_W(TW), .IDX_W(IW)) dut (
      .clk(clk), .resetn(resetn),
      .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_tag(lookup_tag),
      .lookup_ready(lookup_ready),
      .res_valid(res_valid), .res_hit(res_hit), .res_tag(res_tag), .res_v(res_v),
      .refill_valid(refill_valid), .refill_index(refill_index), .refill_tag(refill_tag),
      .refill_ready(refill_ready),
      .inv_valid(inv_valid), .inv_index(inv_index), .inv_ready(inv_ready),
      .flush_req(flush_req), .busy(busy),
      .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
      .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
   );

   always #5 clk = ~clk;

   // Tag RAM: registered read returning pre-write data; holds stale valid
   // garbage while reset is asserted so a missing clear sweep shows up as hits.
   logic [TW:0] mem [N];
   always @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < N; i++) mem[i] <= {1'b1, TW'(32'h5A5A0 + i)};
      end else begin
         if (ram_enb) ram_doutb <= mem[ram_addrb];
         if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
      end
   end

   typedef struct {
      logic          lv;
      logic [IW-1:0] li;
      logic [TW-1:0] lt;
      logic          rv;
      logic [IW-1:0] ri;
      logic [TW-1:0] rt;
      logic          iv;
      logic [IW-1:0] ii;
      logic          fl;
      logic          xl, xr, xi;
   } vec_t;

   typedef struct {
      logic          v;
      logic [TW-1:0] tag;
      logic          hit;
   } res_t;

   vec_t        vt[$];
   res_t        sb[$];
   logic [TW:0] rm [N];
   int          checks = 0;
   int          errors = 0;

   function automatic vec_t mk(input int lv, input int li, input int lt,
                               input int rv, input int ri, input int rt,
                               input int iv, input int ii, input int fl,
                               input int xl, input int xr, input int xi);
      vec_t v;
      v.lv = (lv != 0); v.li = IW'(li); v.lt = TW'(lt);
      v.rv = (rv != 0); v.ri = IW'(ri); v.rt = TW'(rt);
      v.iv = (iv != 0); v.ii = IW'(ii); v.fl = (fl != 0);
      v.xl = (xl != 0); v.xr = (xr != 0); v.xi = (xi != 0);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_result(input string name);
      res_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({name, " res_valid"}, 32'(res_valid), 32'd1);
         chk({name, " res_v"},     32'(res_v),     32'(e.v));
         chk({name, " res_tag"},   32'(res_tag),   32'(e.tag));
         chk({name, " res_hit"},   32'(res_hit),   32'(e.hit));
      end else begin
         chk({name, " res_valid idle"}, 32'(res_valid), 32'd0);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      logic          wr;
      logic [IW-1:0] wi;
      logic [TW:0]   wd, ee;
      res_t          e;
      @(negedge clk);
      lookup_valid = v.lv; lookup_index = v.li; lookup_tag = v.lt;
      refill_valid = v.rv; refill_index = v.ri; refill_tag = v.rt;
      inv_valid    = v.iv; inv_index    = v.ii; flush_req  = v.fl;
      #1;
      check_result(name);
      chk({name, " busy"},         32'(busy),         32'd0);
      chk({name, " lookup_ready"}, 32'(lookup_ready), 32'(v.xl));
      chk({name, " refill_ready"}, 32'(refill_ready), 32'(v.xr));
      chk({name, " inv_ready"},    32'(inv_ready),    32'(v.xi));
      wr = (v.iv && v.xi) || (v.rv && v.xr);
      if (v.iv && v.xi) begin
         wi = v.ii; wd = '0;
      end else begin
         wi = v.ri; wd = {1'b1, v.rt};
      end
      chk({name, " ram_ena"}, 32'(ram_ena), 32'(wr));
      chk({name, " ram_wea"}, 32'(ram_wea), 32'(wr));
      if (wr) begin
         chk({name, " ram_addra"}, 32'(ram_addra), 32'(wi));
         chk({name, " ram_dina"},  32'(ram_dina),  32'(wd));
      end
      chk({name, " ram_enb"}, 32'(ram_enb), 32'(v.lv && v.xl));
      if (v.lv && v.xl) begin
         chk({name, " ram_addrb"}, 32'(ram_addrb), 32'(v.li));
         ee    = (wr && wi == v.li) ? wd : rm[v.li];
         e.v   = ee[TW];
         e.tag = ee[TW-1:0];
         e.hit = e.v && (e.tag == v.lt);
         sb.push_back(e);
      end
      if (wr) rm[wi] = wd;
   endtask

   // Sweep cycles: all requests held high to prove none is accepted.
   task automatic check_sweep(input int n, input string name);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         lookup_valid = 1'b1; refill_valid = 1'b1; inv_valid = 1'b1; flush_req = 1'b1;
         #1;
         check_result($sformatf("%s[%0d]", name, k));
         chk($sformatf("%s[%0d] busy", name, k),      32'(busy),      32'd1);
         chk($sformatf("%s[%0d] ram_ena", name, k),   32'(ram_ena),   32'd1);
         chk($sformatf("%s[%0d] ram_wea", name, k),   32'(ram_wea),   32'd1);
         chk($sformatf("%s[%0d] ram_addra", name, k), 32'(ram_addra), 32'(k));
         chk($sformatf("%s[%0d] ram_dina", name, k),  32'(ram_dina),  32'd0);
         chk($sformatf("%s[%0d] readies", name, k),
             32'({lookup_ready, refill_ready, inv_ready, ram_enb}), 32'd0);
         rm[k] = '0;
      end
   endtask

   task automatic check_reset_state(input string name);
      chk({name, " busy"},      32'(busy),      32'd1);
      chk({name, " res_valid"}, 32'(res_valid), 32'd0);
      chk({name, " ram_en"},    32'({ram_ena, ram_wea, ram_enb}), 32'd0);
      chk({name, " ready"},     32'(lookup_ready), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b1;
      lookup_valid = 1'b0; refill_valid = 1'b0; inv_valid = 1'b0; flush_req = 1'b0;
      lookup_index = '0; refill_index = '0; inv_index = '0;
      lookup_tag = '0; refill_tag = '0;
      #2 resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check_reset_state("reset");
      @(posedge clk); #2 resetn = 1'b1;
      check_sweep(N, "init");

      //          lv li lt        rv ri rt        iv ii fl xl xr xi
      vt.push_back(mk(0, 0, 0,        1, 5, 'hABCDE, 0, 0, 0, 1, 1, 1));
      vt.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0, 0, 1, 1, 1));
      vt.push_back(mk(1, 5, 'hABCDE,  0, 0, 0,       0, 0, 0, 1, 1, 1));
      vt.push_back(mk(1, 5, 'h12345,  0, 0, 0,       0, 0, 0, 1, 1, 1));
      vt.push_back(mk(1, 2, 'h11111,  1, 2, 'h11111, 0, 0, 0, 1, 1, 1));
      vt.push_back(mk(1, 3, 'h11111,  1, 2, 'h11111, 0, 0, 0, 1, 1, 1));
      vt.push_back(mk(0, 0, 0,        1, 4, 'h44444, 0, 0, 0, 1, 1, 1));
      vt.push_back(mk(1, 4, 'h44444,  1, 6, 'h66666, 1, 4, 0, 1, 0, 1));
      vt.push_back(mk(1, 4, 'h44444,  1, 6, 'h66666, 0, 0, 0, 1, 1, 1));
      vt.push_back(mk(1, 6, 'h66666,  0, 0, 0,       0, 0, 0, 1, 1, 1));
      vt.push_back(mk(1, 5, 'hABCDE,  0, 0, 0,       0, 0, 0, 1, 1, 1));
      vt.push_back(mk(0, 0, 0,        1, 5, 'h55555, 0, 0, 0, 1, 1, 1));
      vt.push_back(mk(1, 5, 'h55555,  0, 0, 0,       0, 0, 0, 1, 1, 1));
      vt.push_back(mk(1, 7, 'h7AAAA,  1, 7, 'h7AAAA, 1, 7, 0, 1, 0, 1));
      for (int i = 0; i < N - 1; i++)
         vt.push_back(mk(0, 0, 0, 1, i, 'h10000 + i, 0, 0, 0, 1, 1, 1));
      vt.push_back(mk(1, 7, 'h10007,  1, 7, 'h10007, 0, 0, 0, 1, 1, 1));
      vt.push_back(mk(1, 0, 'h10000,  1, 1, 'h1,     1, 2, 1, 0, 0, 0));
      for (int i = 0; i < N; i++)
         vt.push_back(mk(1, i, 'h10000 + i, 0, 0, 0, 0, 0, 0, 1, 1, 1));

      foreach (vt[i]) begin
         apply(vt[i], $sformatf("v%0d", i));
         if (vt[i].fl) check_sweep(N, $sformatf("flush%0d", i));
      end

      // Reset asserted mid-flush at counter 5: sweep restarts from address 0.
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "flush2");
      check_sweep(5, "part");
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check_reset_state("midflush");
      @(posedge clk); #2 resetn = 1'b1;
      check_sweep(N, "resweep");
      for (int i = 0; i < N; i++)
         apply(mk(1, i, 'h5A5A0 + i, 0, 0, 0, 0, 0, 0, 1, 1, 1), $sformatf("post%0d", i));

      // A pending result is dropped when reset hits in its result cycle.
      @(negedge clk);
      lookup_valid = 1'b1; lookup_index = 3'd3; refill_valid = 1'b0; inv_valid = 1'b0;
      flush_req = 1'b0;
      #1;
      check_result("drop_prev");
      @(posedge clk); #1;
      chk("drop res_valid before", 32'(res_valid), 32'd1);
      resetn = 1'b0;
      #1;
      check_reset_state("drop");
      @(posedge clk); #2 resetn = 1'b1;
      check_sweep(N, "dropsweep");
      apply(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), "last");
      @(negedge clk);
      lookup_valid = 1'b0; refill_valid = 1'b0; inv_valid = 1'b0; flush_req = 1'b0;
      #1;
      check_result("final");
      chk("scoreboard empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
